rv32_ifetch: RTL and testbench
==============================

# rv32_ifetch

Instruction fetch responder for the RV32 core. It sits between the program-counter unit and the instruction memory port. It issues one fetch per PC value over a request/grant/response bus and returns the instruction word with its PC to decode. It drives `busy` back to the PC unit, drops in-flight responses on branch flush, and holds decode output under pipeline stall using a one-entry skid buffer.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `if_pc` and `imem_addr` after reset.

Ports:
- Reset `rst_n` is asynchronous and active-low; the clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `pc`  in  32  fetch address from the PC unit
- `flush`  in  1  branch redirect; kill fetch in flight and output
- `stall`  in  1  decode not accepting; hold `if_*`
- `busy`  out  1  fetch of current `pc` not yet delivered; PC unit must hold
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  request address, word aligned (`[1:0]` forced 0)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  response instruction word
- `if_valid`  out  1  `if_instr`/`if_pc` valid for decode
- `if_instr`  out  32  fetched instruction
- `if_pc`  out  32  address of `if_instr`

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset enters IDLE. IDLE always goes to REQ next cycle.
- REQ: `imem_req`=1 and `imem_addr`={pc[31:2],2'b00}.
  - REQ is suppressed (`imem_req`=0, stay REQ) while `stall`&`if_valid`.
  - On `imem_gnt`: latch `req_pc`, go to WAIT.
- WAIT: `imem_req`=0. Only one request is ever outstanding. On `imem_rvalid`:
  - discard flag set: drop the word, clear the flag, go to REQ.
  - else if `stall`&`if_valid`: write word and `req_pc` into the skid, go to HOLD.
  - else: load `if_instr`/`if_pc`, set `if_valid`=1, go to REQ.
- HOLD: when `stall`=0, move the skid to the output, `if_valid`=1, go to REQ.
- `if_valid` clears when decode consumes an entry (`stall`=0) and no new word loads that cycle.
- flush: in the same cycle, clears `if_valid` and the skid.
  - In WAIT, or in REQ with `imem_gnt`, sets the discard flag.
  - HOLD goes to REQ.
  - flush has priority over `imem_rvalid` in the same cycle; that response is discarded.
- `busy` is combinational: `busy`=0 only in the cycle a non-discarded response is loaded into the output register. Otherwise `busy`=1.
- A skid load keeps `busy`=1 until HOLD drains.

## Timing
- Reset values: `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `busy`=1, skid empty, discard=0.
- Minimum latency is `pc` valid → `if_valid`: 2 cycles with `imem_gnt` in REQ and `imem_rvalid` the next cycle.
- Throughput is one instruction per 2 cycles with zero-wait memory.
- `imem_req`/`imem_addr` are registered-stable while in REQ until `imem_gnt`. The address may change only if `pc` changes, which happens only after flush.
- Reset asserted mid-WAIT: the FSM returns to IDLE. A stale `imem_rvalid` after reset release, while not in WAIT, is ignored.
- `if_*` change only on a load; they are held stable for every cycle of `stall`.

## Test plan
- Reset release, `pc`=0, zero-wait memory returning 32'h00500093 → `imem_req` in cycle 1; `if_valid`=1, `if_instr`=32'h00500093, `if_pc`=0 in cycle 3; `busy`=0 in exactly that load cycle.
- `imem_gnt` delayed 3 cycles, `pc`=0x40 → `imem_addr` holds 0x40 with `imem_req`=1 for all 3 cycles; one fetch only.
- `flush` while in WAIT with `pc` changing 0x10→0x80 → the 0x10 response is dropped and `if_valid` stays 0. The next request has `imem_addr`=0x80, and `if_pc`=0x80.
- `flush` and `imem_rvalid` in the same cycle → word discarded, `if_valid`=0, `busy`=1.
- `stall`=1 with `if_valid`=1 holding pc 0x4, and a response for 0x8 arriving → goes to HOLD with `if_pc`=0x4 unchanged. After `stall` drops: `if_pc`=0x8 the next cycle and no new `imem_req` during the stall.
- `rst_n` asserted mid-WAIT, then `imem_rvalid` pulse after release in IDLE → ignored; outputs equal the reset values.

Source files
------------

// File: rtl/rv32_ifetch.sv
// Instruction fetch responder: one request per PC over a req/gnt/rvalid bus,
// returns instruction and PC to decode with flush discard and a one-entry skid.
module rv32_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        stall,
    output logic        busy,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'h3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_discard;
    logic [XLEN-1:0]   r_req_pc;
    logic [XLEN-1:0]   r_skid_instr;
    logic [XLEN-1:0]   r_skid_pc;
    logic              r_if_valid;
    logic [XLEN-1:0]   r_if_instr;
    logic [XLEN-1:0]   r_if_pc;

    logic [XLEN-1:0]   w_aligned_pc;
    logic              w_hold_out;
    logic              w_req;
    logic              w_accept;
    logic              w_rsp_keep;
    logic              w_load_rsp;
    logic              w_load_skid;
    logic              w_drain;

    // Decode is holding a valid entry: nothing new may be requested or loaded.
    assign w_aligned_pc = pc & ALIGN_MASK;
    assign w_hold_out   = stall & r_if_valid;
    assign w_req        = (r_state == S_REQ) & ~w_hold_out;
    assign w_accept     = w_req & imem_gnt;
    assign w_rsp_keep   = (r_state == S_WAIT) & imem_rvalid & ~r_discard & ~flush;
    assign w_load_rsp   = w_rsp_keep & ~w_hold_out;
    assign w_load_skid  = w_rsp_keep & w_hold_out;
    assign w_drain      = (r_state == S_HOLD) & ~stall & ~flush;

    assign busy      = ~(w_load_rsp | w_drain);
    assign imem_req  = w_req;
    assign imem_addr = (r_state == S_REQ) ? w_aligned_pc : r_req_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_discard    <= 1'b0;
            r_req_pc     <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= NOP_INSTR;
            r_if_pc      <= RESET_PC;
        end else begin
            // Output register: flush kills, loads replace, consumption empties.
            if (flush) begin
                r_if_valid <= 1'b0;
            end else if (w_load_rsp) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= r_req_pc;
            end else if (w_drain) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_skid_instr;
                r_if_pc    <= r_skid_pc;
            end else if (!stall) begin
                r_if_valid <= 1'b0;
            end

            if (w_load_skid) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_req_pc;
            end

            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_accept) begin
                        r_req_pc <= w_aligned_pc;
                        r_state  <= S_WAIT;
                        if (flush) begin
                            r_discard <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_discard <= 1'b0;
                        r_state   <= w_load_skid ? S_HOLD : S_REQ;
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush || !stall) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_ifetch.sv
// Self-checking bench for rv32_ifetch: PC-unit and memory models drive the DUT,
// a scoreboard checks every instruction decode consumes.
module tb_rv32_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = RST_PC;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        busy;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (set by the main sequence)
    int          k_stall = 0;     // 0 off, 1 on, 2 random
    int          k_gnt = 1;       // 0 never, 1 always, 2 random
    int          k_lat_min = 0;
    int          k_lat_max = 0;
    int          k_flush_pct = 0;
    bit          k_flush_now = 1'b0;
    bit          k_flush_on_rsp = 1'b0;
    bit          k_stale = 1'b0;
    logic [31:0] k_flush_pc = 32'h0;
    logic [31:0] pc_init = RST_PC;

    // Reference model state
    logic [31:0] mem [logic [31:0]];
    exp_t        sbq [$];
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] pc_nxt = RST_PC;
    int          n_gnt = 0;
    int          idle_cyc = 0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    rv32_ifetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ev_hit(input int ev);
        case (ev)
            0: return !busy;
            1: return if_valid;
            2: return imem_req && imem_gnt;
            3: return imem_rvalid;
            4: return imem_req;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int ev, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            hit = ev_hit(ev);
        end
        chk(name, {31'b0, hit}, 32'd1);
    endtask

    // Returns at the negedge of the first cycle after reset release (IDLE).
    task automatic reset_to(input logic [31:0] p, input bit stale);
        rst_n   = 1'b0;
        pc_init = p;
        repeat (2) @(posedge clk);
        @(negedge clk);
        k_stale = stale;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, NOP);
        chk({tag, "_if_pc"}, if_pc, RST_PC);
        chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, RST_PC);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    // Driver: PC unit and memory apply inputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            stall = (k_stall == 2) ? ($urandom_range(99) < 32'd30) : (k_stall == 1);
            imem_gnt = (k_gnt == 2) ? ($urandom_range(99) < 32'd60) : (k_gnt == 1);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (m_pend && m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rd(m_addr);
            end
            if (k_stale) begin
                imem_rvalid = 1'b1;
                k_stale = 1'b0;
            end
            flush = 1'b0;
            if (k_flush_now || (k_flush_on_rsp && imem_rvalid)) begin
                flush = 1'b1;
                pc = k_flush_pc;
                k_flush_now = 1'b0;
                k_flush_on_rsp = 1'b0;
            end else if (k_flush_pct > 0 && $urandom_range(99) < 32'(k_flush_pct)) begin
                flush = 1'b1;
                pc = 32'($urandom_range(1023, 0)) << 2;
            end else begin
                pc = pc_nxt;
            end
        end
    end

    // Monitor: models memory/PC unit and scores everything decode accepts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pend = 1'b0;
                m_cnt = 0;
                sbq.delete();
                pc_nxt = pc_init;
                n_gnt = 0;
                idle_cyc = 0;
                hold_prev = 1'b0;
            end else begin
                if (imem_req) begin
                    chk("req_addr", imem_addr, pc & ~32'h3);
                    chk("one_outstanding", {31'b0, m_pend}, 32'd0);
                end
                if (hold_prev) begin
                    chk("stall_hold_valid", {31'b0, if_valid}, 32'd1);
                    chk("stall_hold_pc", if_pc, prev_pc);
                    chk("stall_hold_instr", if_instr, prev_instr);
                end
                hold_prev  = if_valid && stall && !flush;
                prev_pc    = if_pc;
                prev_instr = if_instr;

                if (flush) begin
                    sbq.delete();
                    chk("busy_on_flush", {31'b0, busy}, 32'd1);
                end else if (if_valid && !stall) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_if_valid", {31'b0, if_valid}, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_if_pc", if_pc, e.pc);
                        chk("sb_if_instr", if_instr, e.instr);
                    end
                end

                if (!busy && !flush) begin
                    e.pc    = pc & ~32'h3;
                    e.instr = rd(e.pc);
                    sbq.push_back(e);
                    pc_nxt = pc + 32'd4;
                    idle_cyc = 0;
                end else begin
                    pc_nxt = pc;
                    idle_cyc++;
                end
                if (idle_cyc > 200) begin
                    chk("progress_timeout", 32'(idle_cyc), 32'd0);
                    idle_cyc = 0;
                end

                if (imem_rvalid) begin
                    m_pend = 1'b0;
                end else if (m_pend && m_cnt > 0) begin
                    m_cnt--;
                end
                if (imem_req && imem_gnt) begin
                    m_pend = 1'b1;
                    m_addr = imem_addr;
                    m_cnt  = int'($urandom_range(k_lat_max, k_lat_min));
                    n_gnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end by %0t", $time);
        $fatal(1);
    end

    initial begin
        mem[32'h0] = 32'h0050_0093;

        // Zero-wait memory from reset: cycle-exact latency and busy pulse
        reset_to(32'h0, 1'b0);
        chk_reset_outputs("rst");
        @(negedge clk);
        chk("t1_req_c1", {31'b0, imem_req}, 32'd1);
        chk("t1_addr_c1", imem_addr, 32'h0);
        chk("t1_busy_c1", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_busy_c2", {31'b0, busy}, 32'd0);
        chk("t1_valid_c2", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c3", {31'b0, if_valid}, 32'd1);
        chk("t1_instr_c3", if_instr, 32'h0050_0093);
        chk("t1_pc_c3", if_pc, 32'h0);

        // Grant withheld for three cycles
        k_gnt = 0;
        reset_to(32'h40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_req_held", {31'b0, imem_req}, 32'd1);
            chk("t2_addr_held", imem_addr, 32'h40);
        end
        k_gnt = 1;
        wait_ev(0, "t2_load_seen");
        chk("t2_one_fetch", 32'(n_gnt), 32'd1);
        @(negedge clk);
        chk("t2_if_pc", if_pc, 32'h40);

        // Flush in WAIT with redirect 0x10 -> 0x80
        k_lat_min = 3;
        k_lat_max = 3;
        reset_to(32'h10, 1'b0);
        wait_ev(2, "t3_gnt_seen");
        k_flush_pc  = 32'h80;
        k_flush_now = 1'b1;
        @(negedge clk);
        chk("t3_busy_flush", {31'b0, busy}, 32'd1);
        wait_ev(4, "t3_next_req");
        chk("t3_next_addr", imem_addr, 32'h80);
        chk("t3_dropped", {31'b0, if_valid}, 32'd0);
        wait_ev(1, "t3_valid_seen");
        chk("t3_if_pc", if_pc, 32'h80);
        chk("t3_if_instr", if_instr, rd(32'h80));

        // Flush in the same cycle as the response
        k_lat_min = 1;
        k_lat_max = 1;
        reset_to(32'h100, 1'b0);
        k_flush_pc = 32'h200;
        k_flush_on_rsp = 1'b1;
        wait_ev(3, "t4_rsp_seen");
        chk("t4_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("t4_valid", {31'b0, if_valid}, 32'd0);
        wait_ev(1, "t4_valid_seen");
        chk("t4_if_pc", if_pc, 32'h200);

        // Stall while decode holds pc 0x4
        k_lat_min = 0;
        k_lat_max = 0;
        reset_to(32'h4, 1'b0);
        wait_ev(0, "t5_load_seen");
        k_stall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_valid_stall", {31'b0, if_valid}, 32'd1);
            chk("t5_pc_stall", if_pc, 32'h4);
            chk("t5_no_req", {31'b0, imem_req}, 32'd0);
        end
        k_stall = 0;
        wait_ev(0, "t5_next_load");
        @(negedge clk);
        chk("t5_if_pc_next", if_pc, 32'h8);
        chk("t5_valid_next", {31'b0, if_valid}, 32'd1);

        // Reset mid-WAIT, then a stale response in IDLE
        k_lat_min = 20;
        k_lat_max = 20;
        reset_to(32'h300, 1'b0);
        wait_ev(2, "t6_gnt_seen");
        repeat (2) @(negedge clk);
        k_lat_min = 0;
        k_lat_max = 0;
        reset_to(32'h300, 1'b1);
        chk_reset_outputs("t6_idle");
        @(negedge clk);
        chk("t6_valid_c1", {31'b0, if_valid}, 32'd0);
        chk("t6_instr_c1", if_instr, NOP);
        chk("t6_pc_c1", if_pc, RST_PC);
        chk("t6_req_c1", {31'b0, imem_req}, 32'd1);

        // Randomized traffic against the scoreboard
        k_stall = 2;
        k_gnt = 2;
        k_lat_min = 0;
        k_lat_max = 3;
        k_flush_pct = 4;
        repeat (3000) @(negedge clk);
        k_stall = 0;
        k_gnt = 1;
        k_lat_max = 0;
        k_flush_pct = 0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
